// File: rtl/dpc_autobp_list_collector_if.sv
// Bus bundle for the auto bad-pixel list collector: detection stream in,
// published-list status and host read port out.
interface dpc_autobp_list_collector_if #(
  parameter int CNT_WIDTH      = 10,
  parameter int AUTO_BP_BIT    = 8,
  parameter int FRAME_ID_WIDTH = 16
);
  logic                      enable;
  logic                      sof;
  logic                      bp_valid;
  logic [CNT_WIDTH-1:0]      bp_x;
  logic [CNT_WIDTH-1:0]      bp_y;
  logic                      frame_done;
  logic                      host_ack;
  // Read handshake: each rd_en cycle yields exactly one rd_valid pulse on the
  // following cycle with rd_data; there is no backpressure on either side.
  logic                      rd_en;
  logic [AUTO_BP_BIT-1:0]    rd_addr;
  logic [31:0]               rd_data;
  logic                      rd_valid;
  logic                      list_ready;
  logic [AUTO_BP_BIT:0]      list_count;
  logic                      list_overflow;
  logic [FRAME_ID_WIDTH-1:0] list_frame_id;
  logic [15:0]               dropped_frames;
  logic                      busy;
  logic [1:0]                dbg_state;

  modport master (
    output enable, sof, bp_valid, bp_x, bp_y, frame_done, host_ack, rd_en, rd_addr,
    input  rd_data, rd_valid, list_ready, list_count, list_overflow, list_frame_id,
           dropped_frames, busy, dbg_state
  );

  modport slave (
    input  enable, sof, bp_valid, bp_x, bp_y, frame_done, host_ack, rd_en, rd_addr,
    output rd_data, rd_valid, list_ready, list_count, list_overflow, list_frame_id,
           dropped_frames, busy, dbg_state
  );
endinterface

// File: rtl/dpc_autobp_list_collector.sv
// Collects one frame of auto-detected bad-pixel coordinates into a ping-pong
// buffer and publishes the finished list to the host read port.
module dpc_autobp_list_collector #(
  parameter int CNT_WIDTH      = 10,
  parameter int AUTO_BP_NUM    = 256,
  parameter int AUTO_BP_BIT    = 8,
  parameter int FRAME_ID_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  dpc_autobp_list_collector_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  localparam logic [AUTO_BP_BIT:0] FULL = (AUTO_BP_BIT+1)'(AUTO_BP_NUM);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [AUTO_BP_BIT:0]      r_wr_ptr;
  logic                      r_ovf_acc;
  logic                      r_wr_bank;
  logic [FRAME_ID_WIDTH-1:0] r_frame_id;
  logic                      r_list_ready;
  logic [AUTO_BP_BIT:0]      r_list_count;
  logic                      r_list_overflow;
  logic [FRAME_ID_WIDTH-1:0] r_list_frame_id;
  logic [15:0]               r_dropped;
  logic [31:0]               r_rd_data;
  logic                      r_rd_valid;
  logic [31:0]               r_mem [0:2*AUTO_BP_NUM-1];

  logic                      w_start;
  logic                      w_abort;
  logic                      w_wr;
  logic                      w_ovf_set;
  logic                      w_commit;
  logic                      w_publish;
  logic                      w_rd_hit;
  logic [AUTO_BP_BIT-1:0]    w_wr_idx;
  logic [31:0]               w_entry;

  assign w_entry  = {{(16-CNT_WIDTH){1'b0}}, bus.bp_y, {(16-CNT_WIDTH){1'b0}}, bus.bp_x};
  // A restart sof puts its own pixel at index 0 of the new frame.
  assign w_wr_idx = w_abort ? '0 : r_wr_ptr[AUTO_BP_BIT-1:0];
  // host_ack in the commit cycle frees the read bank before the publish check.
  assign w_publish = w_commit & ~(r_list_ready & ~bus.host_ack);
  assign w_rd_hit  = r_list_ready && ({1'b0, bus.rd_addr} < r_list_count);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_wr        = 1'b0;
    w_ovf_set   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sof && bus.enable) begin
          w_state_nxt = S_COLLECT;
          w_start     = 1'b1;
        end
      end
      S_COLLECT: begin
        if (bus.frame_done) w_state_nxt = S_COMMIT;
        else if (bus.sof)   w_abort     = 1'b1;
        if (bus.bp_valid) begin
          if (w_abort || (r_wr_ptr < FULL)) w_wr      = 1'b1;
          else                              w_ovf_set = 1'b1;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= S_IDLE;
      r_wr_ptr        <= '0;
      r_ovf_acc       <= 1'b0;
      r_wr_bank       <= 1'b0;
      r_frame_id      <= '0;
      r_list_ready    <= 1'b0;
      r_list_count    <= '0;
      r_list_overflow <= 1'b0;
      r_list_frame_id <= '0;
      r_dropped       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_wr_ptr  <= '0;
        r_ovf_acc <= 1'b0;
      end else if (w_abort) begin
        r_wr_ptr  <= (AUTO_BP_BIT+1)'(w_wr);
        r_ovf_acc <= 1'b0;
      end else begin
        if (w_wr)      r_wr_ptr  <= r_wr_ptr + 1'b1;
        if (w_ovf_set) r_ovf_acc <= 1'b1;
      end
      if ((w_abort || (w_commit && !w_publish)) && (r_dropped != 16'hFFFF))
        r_dropped <= r_dropped + 1'b1;
      if (w_commit) r_frame_id <= r_frame_id + 1'b1;
      if (w_publish) begin
        r_wr_bank       <= ~r_wr_bank;
        r_list_count    <= r_wr_ptr;
        r_list_overflow <= r_ovf_acc;
        r_list_frame_id <= r_frame_id + 1'b1;
        r_list_ready    <= 1'b1;
      end else if (bus.host_ack) begin
        r_list_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_wr) r_mem[{r_wr_bank, w_wr_idx}] <= w_entry;
  end

  // Reads always hit the bank opposite the one being filled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_rd_data  <= (bus.rd_en && w_rd_hit) ? r_mem[{~r_wr_bank, bus.rd_addr}] : '0;
    end
  end

  assign bus.rd_data        = r_rd_data;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.list_ready     = r_list_ready;
  assign bus.list_count     = r_list_count;
  assign bus.list_overflow  = r_list_overflow;
  assign bus.list_frame_id  = r_list_frame_id;
  assign bus.dropped_frames = r_dropped;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_dpc_autobp_list_collector.sv
// Directed-plus-random bench for the auto bad-pixel list collector, checked
// against a frame-level queue model of the published list.
module tb_dpc_autobp_list_collector;
  localparam int CW  = 10;
  localparam int NUM = 256;
  localparam int AB  = 8;
  localparam int FW  = 16;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  dpc_autobp_list_collector_if #(.CNT_WIDTH(CW), .AUTO_BP_BIT(AB), .FRAME_ID_WIDTH(FW)) bus ();

  dpc_autobp_list_collector #(
    .CNT_WIDTH(CW), .AUTO_BP_NUM(NUM), .AUTO_BP_BIT(AB), .FRAME_ID_WIDTH(FW)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];   // published list as the host should see it
  logic [31:0] cur_q[$];   // list of the frame being collected
  bit          cur_ovf;
  bit          m_ready;
  bit          m_ovf;
  int          m_frame_id;
  int          m_pub_id;
  int          m_dropped;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {16'(y), 16'(x)};
  endfunction

  task automatic model_reset();
    exp_q.delete(); cur_q.delete();
    cur_ovf = 0; m_ready = 0; m_ovf = 0;
    m_frame_id = 0; m_pub_id = 0; m_dropped = 0;
  endtask

  task automatic model_pixel(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (cur_q.size() < NUM) cur_q.push_back(ent(x, y));
    else cur_ovf = 1;
  endtask

  task automatic model_commit(input bit ack);
    if (ack) m_ready = 0;
    m_frame_id++;
    if (!m_ready) begin
      exp_q    = cur_q;
      m_ovf    = cur_ovf;
      m_pub_id = m_frame_id;
      m_ready  = 1;
    end else if (m_dropped < 65535) begin
      m_dropped++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic pix(input bit s, input bit v, input bit fd, input bit ack,
                     input logic [CW-1:0] x, input logic [CW-1:0] y);
    bus.sof = s; bus.bp_valid = v; bus.frame_done = fd; bus.host_ack = ack;
    bus.bp_x = x; bus.bp_y = y;
    cyc();
    bus.sof = 0; bus.bp_valid = 0; bus.frame_done = 0; bus.host_ack = 0;
  endtask

  function automatic logic [CW-1:0] rc();
    return CW'($urandom_range(0, (1 << CW) - 1));
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".ready"},   32'(bus.list_ready),     32'(m_ready));
    check({tag, ".count"},   32'(bus.list_count),     32'(exp_q.size()));
    check({tag, ".ovf"},     32'(bus.list_overflow),  32'(m_ovf));
    check({tag, ".id"},      32'(bus.list_frame_id),  32'(m_pub_id[FW-1:0]));
    check({tag, ".dropped"}, 32'(bus.dropped_frames), 32'(m_dropped));
    check({tag, ".busy"},    32'(bus.busy),           32'd0);
  endtask

  task automatic read_check(input string tag);
    int last;
    last = (exp_q.size() < NUM) ? exp_q.size() : NUM - 1;
    for (int i = 0; i <= last; i++) begin
      bus.rd_en = 1; bus.rd_addr = AB'(i);
      cyc();
      bus.rd_en = 0;
      check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd1);
      check({tag, ".rd_data"},  bus.rd_data, (m_ready && i < exp_q.size()) ? exp_q[i] : 32'd0);
      cyc();
      check({tag, ".rd_pulse"}, 32'(bus.rd_valid), 32'd0);
    end
  endtask

  task automatic ack_cycle();
    pix(0, 0, 0, 1, 0, 0);
    m_ready = 0;
    check("ack_clear", 32'(bus.list_ready), 32'd0);
  endtask

  task automatic send_frame(input int n, input bit ack_at_commit);
    bit v;
    logic [CW-1:0] x, y;
    cur_q.delete(); cur_ovf = 0;
    bus.enable = 1;
    pix(1, 1'($urandom_range(0, 1)), 0, 0, rc(), rc());   // bp_valid in IDLE is ignored
    check("busy_collect", 32'(bus.busy), 32'd1);
    bus.enable = 1'($urandom_range(0, 1));                // mid-frame enable has no effect
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) pix(0, 0, 0, 0, rc(), rc());
      x = rc(); y = rc();
      pix(0, 1, 0, 0, x, y);
      model_pixel(x, y);
    end
    v = 1'($urandom_range(0, 1)); x = rc(); y = rc();
    pix(0, v, 1, 0, x, y);
    if (v) model_pixel(x, y);
    check("busy_commit", 32'(bus.busy), 32'd1);
    pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, ack_at_commit, rc(), rc());
    model_commit(ack_at_commit);
    bus.enable = 1;
    check_status("frame");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CW-1:0] x, y;
    int k;
    bus.enable = 1; bus.sof = 0; bus.bp_valid = 0; bus.bp_x = 0; bus.bp_y = 0;
    bus.frame_done = 0; bus.host_ack = 0; bus.rd_en = 0; bus.rd_addr = 0;
    model_reset();
    repeat (3) cyc();
    check_status("reset");
    check("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset.rd_data",  bus.rd_data, 32'd0);
    aresetn = 1;
    cyc();

    // Directed three-pixel frame
    cur_q.delete(); cur_ovf = 0;
    pix(1, 0, 0, 0, 0, 0);
    pix(0, 1, 0, 0, 10'd3, 10'd5);   model_pixel(10'd3, 10'd5);
    pix(0, 1, 0, 0, 10'd639, 10'd0); model_pixel(10'd639, 10'd0);
    pix(0, 1, 0, 0, 10'd0, 10'd511); model_pixel(10'd0, 10'd511);
    pix(0, 0, 1, 0, 0, 0);
    pix(0, 0, 0, 0, 0, 0);
    model_commit(0);
    check_status("directed");
    bus.rd_en = 1; bus.rd_addr = 8'd1;
    cyc();
    bus.rd_en = 0;
    check("directed.entry1", bus.rd_data, 32'h0000027F);
    read_check("directed");

    // Overflowing frame
    ack_cycle();
    send_frame(300, 0);
    read_check("overflow");

    // List still held: next frame is dropped, contents unchanged
    send_frame($urandom_range(1, 20), 0);
    read_check("dropped");
    ack_cycle();
    read_check("acked_empty");
    send_frame($urandom_range(1, 20), 0);
    read_check("after_ack");

    // host_ack landing in the commit cycle
    send_frame($urandom_range(1, 20), 1);
    read_check("ack_at_commit");

    // Mid-frame sof restarts the list
    ack_cycle();
    cur_q.delete(); cur_ovf = 0;
    pix(1, 0, 0, 0, 0, 0);
    k = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) begin
      x = rc(); y = rc(); pix(0, 1, 0, 0, x, y); model_pixel(x, y);
    end
    m_dropped++; cur_q.delete(); cur_ovf = 0;
    x = rc(); y = rc(); pix(1, 1, 0, 0, x, y); model_pixel(x, y);
    check("abort.dropped", 32'(bus.dropped_frames), 32'(m_dropped));
    check("abort.busy", 32'(bus.busy), 32'd1);
    k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) begin
      x = rc(); y = rc(); pix(0, 1, 0, 0, x, y); model_pixel(x, y);
    end
    pix(0, 0, 1, 0, 0, 0);
    pix(0, 0, 0, 0, 0, 0);
    model_commit(0);
    check_status("abort");
    read_check("abort");

    // Disabled: nothing collected or published
    ack_cycle();
    bus.enable = 0;
    pix(1, 1, 0, 0, rc(), rc());
    check("disabled.busy_sof", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) pix(0, 1, 0, 0, rc(), rc());
    pix(0, 1, 1, 0, rc(), rc());
    pix(0, 0, 0, 0, 0, 0);
    bus.enable = 1;
    check_status("disabled");

    // Random frames with random host acknowledgements
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) ack_cycle();
      send_frame($urandom_range(0, 12), 1'($urandom_range(0, 1)));
      read_check("random");
    end

    // Reset asserted mid-collection
    ack_cycle();
    send_frame($urandom_range(1, 8), 0);
    pix(1, 0, 0, 0, 0, 0);
    pix(0, 1, 0, 0, rc(), rc());
    bus.rd_en = 1; bus.rd_addr = 0;
    pix(0, 1, 0, 0, rc(), rc());
    bus.rd_en = 0;
    check("prereset.rd_valid", 32'(bus.rd_valid), 32'd1);
    #2 aresetn = 0;
    #1;
    model_reset();
    check_status("async_reset");
    check("async_reset.rd_valid", 32'(bus.rd_valid), 32'd0);
    check("async_reset.rd_data",  bus.rd_data, 32'd0);
    cyc();
    aresetn = 1;
    cyc();
    send_frame($urandom_range(1, 8), 0);
    read_check("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
